// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-port unified memory between the instruction-fetch port
//   (I, read-only) and the load/store port (D, read/write). One transaction is
//   in flight at a time. Ties are broken round-robin. A per-access timeout turns
//   a silent memory into an error response, so the core never hangs.
//
// Ports
//   clk, reset            rising-edge clock, synchronous active-high reset
//   i_req/i_addr          I-port request (held until i_ack)
//   i_ack/i_rdata         I-port completion pulse and read data
//   d_req/d_we/d_addr/d_wdata   D-port request (held until d_ack)
//   d_ack/d_rdata         D-port completion pulse and read data (0 on writes)
//   err                   set together with the ack when the access timed out
//   mem_req/mem_we/mem_addr/mem_wdata   one-cycle command strobe to memory
//   mem_rvalid/mem_rdata  memory completion (read data valid or write done)
//
// Every output is a register. Flow: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
module mem_port_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16   // must be >= 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_ack,
    output logic [DATA_W-1:0] i_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ack,
    output logic [DATA_W-1:0] d_rdata,
    output logic              err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int CNT_W = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t           state, next_state;
    logic [CNT_W-1:0] cnt;
    logic             owner;       // 1 = D port owns the access in flight
    logic             we;          // latched write flag of the access in flight
    logic             last_grant;  // 1 = D was granted last
    logic             grant;       // IDLE is granting this cycle
    logic             grant_d;     // ...and the winner is D
    logic             finish;      // WAIT ends this cycle (data or timeout)

    always_comb begin
        next_state = state;
        grant      = 1'b0;
        grant_d    = 1'b0;
        finish     = 1'b0;
        unique case (state)
            IDLE: begin
                if (i_req || d_req) begin
                    grant = 1'b1;
                    // D wins a tie only if I was served last.
                    grant_d    = d_req && (!i_req || !last_grant);
                    next_state = ISSUE;
                end
            end
            ISSUE: next_state = WAIT;
            WAIT: begin
                // rvalid on the final count still counts as a good response.
                if (mem_rvalid || cnt == CNT_LAST) begin
                    finish     = 1'b1;
                    next_state = RESP;
                end
            end
            RESP:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            owner      <= 1'b0;
            we         <= 1'b0;
            last_grant <= 1'b0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            i_ack      <= 1'b0;
            i_rdata    <= '0;
            d_ack      <= 1'b0;
            d_rdata    <= '0;
            err        <= 1'b0;
        end else begin
            state     <= next_state;
            // Strobes and their qualified data default low each cycle.
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            i_ack     <= 1'b0;
            i_rdata   <= '0;
            d_ack     <= 1'b0;
            d_rdata   <= '0;
            err       <= 1'b0;

            // The command registers double as the latch of the granted request;
            // they are presented for exactly the ISSUE cycle.
            if (grant) begin
                owner      <= grant_d;
                last_grant <= grant_d;
                we         <= grant_d & d_we;
                mem_req    <= 1'b1;
                mem_we     <= grant_d & d_we;
                mem_addr   <= grant_d ? d_addr : i_addr;
                mem_wdata  <= grant_d ? d_wdata : '0;
            end

            if (state == ISSUE)
                cnt <= '0;
            else if (state == WAIT)
                cnt <= cnt + CNT_W'(1);

            if (finish) begin
                err <= !mem_rvalid;
                if (owner) begin
                    d_ack   <= 1'b1;
                    d_rdata <= (mem_rvalid && !we) ? mem_rdata : '0;
                end else begin
                    i_ack   <= 1'b1;
                    i_rdata <= mem_rvalid ? mem_rdata : '0;
                end
            end
        end
    end

endmodule
